// File: rtl/bus_rr_arbiter_pkg.sv
// Shared encodings for the round-robin bus arbiter: FSM states, source
// indices and the grant decode.
package bus_rr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  localparam logic [1:0] SRC_A = 2'd0;
  localparam logic [1:0] SRC_B = 2'd1;
  localparam logic [1:0] SRC_C = 2'd2;
  localparam logic [1:0] SRC_D = 2'd3;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    onehot4 = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/bus_rr_arbiter_if.sv
// Request/grant and valid/ready handshake between the four sources, the
// arbiter and the downstream consumer.
interface bus_rr_arbiter_if #(
  parameter int unsigned CNT_W = 8
);
  logic [3:0]       REQ;
  logic             OUT_READY;
  logic [1:0]       SEL;
  logic [3:0]       GNT;
  logic             OUT_VALID;
  logic [CNT_W-1:0] BEAT;

  modport slave (
    input  REQ, OUT_READY,
    output SEL, GNT, OUT_VALID, BEAT
  );

  modport master (
    output REQ, OUT_READY,
    input  SEL, GNT, OUT_VALID, BEAT
  );
endinterface

// File: rtl/bus_rr_arbiter_rr_pick4.sv
// Combinational round-robin picker: first set request scanning upward from
// last_i+1 with wrap; last_i itself is checked last.
module rr_pick4 (
  input  logic [3:0] req_i,
  input  logic [1:0] last_i,
  output logic [1:0] winner_o,
  output logic       any_o
);

  logic [1:0] idx;

  always_comb begin
    winner_o = last_i;
    idx      = last_i;
    any_o    = |req_i;
    // Walk the priority order backwards so the highest-priority hit wins.
    for (int k = 4; k >= 1; k--) begin
      idx = last_i + 2'(k);
      if (req_i[idx]) winner_o = idx;
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter driving the 4:1 bus mux select, with burst-limited
// ownership and a valid/ready qualifier toward the consumer.
//
// state    | meaning
// ST_IDLE  | no owner; GNT=0, SEL holds last owner
// ST_GRANT | SEL owns the bus; OUT_VALID follows the owner's REQ
module bus_rr_arbiter
  import bus_rr_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  bus_rr_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(MAX_BURST - 1);

  state_e           state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       last_q, last_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [CNT_W-1:0] beat_q, beat_d;

  logic [1:0] pick_ptr;
  logic [1:0] winner;
  logic       any_req;
  logic       owner_req;
  logic       valid;
  logic       xfer;
  logic       burst_end;
  logic       rel_grant;

  assign owner_req = bus.REQ[sel_q];
  assign valid     = (state_q == ST_GRANT) && owner_req;
  assign xfer      = valid && bus.OUT_READY;
  assign burst_end = xfer && (beat_q == BEAT_LAST);
  assign rel_grant = (state_q == ST_GRANT) && (burst_end || !owner_req);

  // On release the outgoing owner becomes the pointer, so it ranks last.
  assign pick_ptr = rel_grant ? sel_q : last_q;

  rr_pick4 u_pick (
    .req_i    (bus.REQ),
    .last_i   (pick_ptr),
    .winner_o (winner),
    .any_o    (any_req)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= SRC_A;
      last_q  <= SRC_D;
      gnt_q   <= 4'b0000;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    beat_d  = beat_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_GRANT;
          sel_d   = winner;
          gnt_d   = onehot4(winner);
          beat_d  = '0;
        end
      end
      ST_GRANT: begin
        if (rel_grant) begin
          last_d = sel_q;
          beat_d = '0;
          if (any_req) begin
            sel_d = winner;
            gnt_d = onehot4(winner);
          end else begin
            state_d = ST_IDLE;
            gnt_d   = 4'b0000;
          end
        end else if (xfer) begin
          beat_d = beat_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 4'b0000;
        beat_d  = '0;
      end
    endcase
  end

  assign bus.SEL       = sel_q;
  assign bus.GNT       = gnt_q;
  assign bus.BEAT      = beat_q;
  assign bus.OUT_VALID = valid;

endmodule
